// File: rtl/div16u_seq.sv
// ---------------------------------------------------------------------------
// div16u_seq - iterative unsigned 16/8 restoring divider.
//
// Produces one quotient bit per clock, MSB first. The partial remainder is
// 9 bits wide, so the trial compare cannot overflow.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous, active-low reset
//   start        request; sampled only while IDLE
//   dividend     16-bit unsigned dividend, captured when start is accepted
//   divisor      8-bit unsigned divisor, captured when start is accepted
//   busy         high from acceptance until the result is posted
//   done         one-cycle pulse; quotient/remainder/div_by_zero valid then
//   quotient     16-bit quotient (16'hFFFF on divide by zero)
//   remainder    8-bit remainder (dividend[7:0] on divide by zero)
//   div_by_zero  set when the most recent result had a zero divisor
//
// Handshake: start is a single-cycle request that is taken only in IDLE.
// Nothing is queued; a request made while busy or during the done cycle is
// dropped. Results hold from one done pulse until the next, or until reset.
// ---------------------------------------------------------------------------
module div16u_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;      // index of the quotient bit produced this cycle
  logic [15:0] dvd_r;
  logic [7:0]  dvs_r;
  logic [8:0]  prem;     // partial remainder
  logic [15:0] q_work;

  // One restoring step: shift in the next dividend bit, then trial-subtract.
  logic [8:0]  shifted;
  logic        fits;
  logic [8:0]  prem_next;
  logic [15:0] q_next;

  always_comb begin
    shifted = {prem[7:0], dvd_r[cnt[3:0]]};
    // prem stays below the divisor, so prem[8] is always 0 on entry. It is
    // ORed in anyway so that a carried-out bit still counts as "fits".
    fits      = prem[8] | (shifted >= {1'b0, dvs_r});
    prem_next = fits ? (shifted - {1'b0, dvs_r}) : shifted;
    q_next    = q_work;
    q_next[cnt[3:0]] = fits;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= 5'd0;
      dvd_r       <= 16'd0;
      dvs_r       <= 8'd0;
      prem        <= 9'd0;
      q_work      <= 16'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= 16'd0;
      remainder   <= 8'd0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            dvd_r  <= dividend;
            dvs_r  <= divisor;
            prem   <= 9'd0;
            q_work <= 16'd0;
            cnt    <= 5'd15;
            busy   <= 1'b1;
            state  <= S_CALC;
          end
        end

        S_CALC: begin
          if (dvs_r == 8'd0) begin
            // A zero divisor spends a single busy cycle here without
            // iterating. It then posts the fixed divide-by-zero result.
            quotient    <= 16'hFFFF;
            remainder   <= dvd_r[7:0];
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_DONE;
          end else begin
            prem   <= prem_next;
            q_work <= q_next;
            cnt    <= cnt - 5'd1;
            if (cnt == 5'd0) begin
              quotient    <= q_next;
              remainder   <= prem_next[7:0];
              div_by_zero <= 1'b0;
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= S_DONE;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
